// File: rtl/data_mem_arbiter.sv
// Two-port round-robin arbiter sharing one data_memory; an ID FIFO routes each
// rvalid back to its issuer. Define DATA_MEM_ARB_PERF_EN to add perf counters.
`timescale 1ns/1ps
module data_mem_arbiter #(
  parameter int MAX_OUTSTANDING = 2,
  parameter int ADDR_WIDTH      = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,

  input  logic                  p0_req_i,
  output logic                  p0_gnt_o,
  output logic                  p0_rvalid_o,
  input  logic                  p0_we_i,
  input  logic [3:0]            p0_be_i,
  input  logic [ADDR_WIDTH-1:0] p0_addr_i,
  input  logic [31:0]           p0_wdata_i,
  output logic [31:0]           p0_rdata_o,

  input  logic                  p1_req_i,
  output logic                  p1_gnt_o,
  output logic                  p1_rvalid_o,
  input  logic                  p1_we_i,
  input  logic [3:0]            p1_be_i,
  input  logic [ADDR_WIDTH-1:0] p1_addr_i,
  input  logic [31:0]           p1_wdata_i,
  output logic [31:0]           p1_rdata_o,

  output logic                  mem_en_o,
  output logic                  mem_req_o,
  input  logic                  mem_gnt_i,
  input  logic                  mem_rvalid_i,
  output logic                  mem_we_o,
  output logic [3:0]            mem_be_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [31:0]           mem_wdata_o,
  input  logic [31:0]           mem_rdata_i,

  output logic                  rsp_err_o
`ifdef DATA_MEM_ARB_PERF_EN
  ,
  output logic [31:0]           perf_gnt0_o,
  output logic [31:0]           perf_gnt1_o,
  output logic [31:0]           perf_conflict_o
`endif
);

  localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_OUTSTANDING);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(MAX_OUTSTANDING - 1);

  logic                       prio_q;
  logic [CNT_W-1:0]           count_q;
  logic [PTR_W-1:0]           wr_ptr_q;
  logic [PTR_W-1:0]           rd_ptr_q;
  logic [MAX_OUTSTANDING-1:0] id_q;
  logic                       rsp_err_q;

  logic any_req;
  logic both_req;
  logic sel;
  logic attr_sel;
  logic fifo_full;
  logic fifo_empty;
  logic handshake;
  logic pop;
  logic head_id;

  // Pointers wrap modulo MAX_OUTSTANDING, which need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
  endfunction

  assign any_req    = p0_req_i | p1_req_i;
  assign both_req   = p0_req_i & p1_req_i;
  assign sel        = both_req ? prio_q : p1_req_i;
  assign fifo_full  = (count_q == CNT_MAX);
  assign fifo_empty = (count_q == '0);

  // Full is judged on the registered count, so a same-cycle pop never frees a slot early.
  assign mem_req_o  = rst_ni & any_req & ~fifo_full;
  assign mem_en_o   = mem_req_o;
  assign handshake  = mem_req_o & mem_gnt_i;
  assign attr_sel   = mem_req_o & sel;

  assign mem_we_o    = attr_sel ? p1_we_i    : p0_we_i;
  assign mem_be_o    = attr_sel ? p1_be_i    : p0_be_i;
  assign mem_addr_o  = attr_sel ? p1_addr_i  : p0_addr_i;
  assign mem_wdata_o = attr_sel ? p1_wdata_i : p0_wdata_i;

  assign p0_gnt_o = handshake & ~sel;
  assign p1_gnt_o = handshake &  sel;

  assign head_id     = id_q[rd_ptr_q];
  assign pop         = mem_rvalid_i & ~fifo_empty;
  assign p0_rvalid_o = pop & ~head_id;
  assign p1_rvalid_o = pop &  head_id;
  assign p0_rdata_o  = mem_rdata_i;
  assign p1_rdata_o  = mem_rdata_i;
  assign rsp_err_o   = rsp_err_q;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prio_q    <= 1'b0;
      count_q   <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      rsp_err_q <= 1'b0;
    end else begin
      if (handshake) begin
        prio_q   <= ~sel;
        wr_ptr_q <= ptr_inc(wr_ptr_q);
      end
      if (pop) begin
        rd_ptr_q <= ptr_inc(rd_ptr_q);
      end
      if (handshake && !pop) begin
        count_q <= count_q + CNT_W'(1);
      end else if (pop && !handshake) begin
        count_q <= count_q - CNT_W'(1);
      end
      if (mem_rvalid_i && fifo_empty) begin
        rsp_err_q <= 1'b1;
      end
    end
  end

  // NOTE: ID storage has no reset; entries are only read between push and pop, which count_q guards.
  always_ff @(posedge clk_i) begin
    if (handshake) begin
      id_q[wr_ptr_q] <= sel;
    end
  end

`ifdef DATA_MEM_ARB_PERF_EN
  logic [31:0] perf_gnt0_q;
  logic [31:0] perf_gnt1_q;
  logic [31:0] perf_conflict_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      perf_gnt0_q     <= '0;
      perf_gnt1_q     <= '0;
      perf_conflict_q <= '0;
    end else begin
      if (p0_gnt_o) perf_gnt0_q <= perf_gnt0_q + 32'd1;
      if (p1_gnt_o) perf_gnt1_q <= perf_gnt1_q + 32'd1;
      if (both_req && mem_req_o) perf_conflict_q <= perf_conflict_q + 32'd1;
    end
  end

  assign perf_gnt0_o     = perf_gnt0_q;
  assign perf_gnt1_o     = perf_gnt1_q;
  assign perf_conflict_o = perf_conflict_q;
`endif

endmodule
